// File: rtl/meas_fifo_pkg.sv
// Shared definitions for the frequency-measurement path and its result FIFO.
// The measurement stage and meas_fifo both import this package.
package meas_fifo_pkg;

   localparam int MEAS_DW         = 64;
   localparam int MEAS_FIFO_DEPTH = 16;

   // One measurement result: reference count in the upper half, signal count in the lower.
   typedef struct packed {
      logic [31:0] ref_cnt;
      logic [31:0] sig_cnt;
   } meas_word_t;

endpackage

// File: rtl/meas_fifo_mem.sv
// DEPTH x DW register array: one synchronous write port, one asynchronous read port.
// Contents have no reset; only the pointers in meas_fifo define what is valid.
module fifo_mem #(
   parameter int DEPTH = 16,
   parameter int DW    = 64,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          wr_en_i,
   input  logic [AW-1:0] wr_addr_i,
   input  logic [DW-1:0] wr_data_i,
   input  logic [AW-1:0] rd_addr_i,
   output logic [DW-1:0] rd_data_o
);

   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem[wr_addr_i] <= wr_data_i;
      end
   end

   assign rd_data_o = mem[rd_addr_i];

endmodule

// File: rtl/meas_fifo.sv
// Measurement result FIFO: accepts 64-bit words, drains them as two 32-bit reads
// (low half first), with level, full/empty, sticky overflow and threshold interrupt.
module meas_fifo
   import meas_fifo_pkg::*;
#(
   parameter int DEPTH = MEAS_FIFO_DEPTH,
   parameter int DW    = MEAS_DW,
   parameter int LW    = $clog2(DEPTH) + 1
) (
   input  logic            clk_i,
   input  logic            rst_n_i,
   input  logic            wr_en_i,
   input  logic [DW-1:0]   wr_data_i,
   input  logic            rd_en_i,
   output logic [DW/2-1:0] rd_data_o,
   output logic            rd_valid_o,
   input  logic            clr_i,
   input  logic [LW-1:0]   thresh_i,
   output logic [LW-1:0]   level_o,
   output logic            empty_o,
   output logic            full_o,
   output logic            overflow_o,
   output logic            irq_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int HW = DW / 2;

   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [LW-1:0] level_reg;
   logic          hi_sel_reg;
   logic          overflow_reg;
   logic          rd_valid_reg;
   logic [HW-1:0] rd_data_reg;

   logic [DW-1:0] head_word;
   logic          empty;
   logic          full;
   logic          pop;
   logic          wr_accept;
   logic          wr_drop;

   assign empty = (level_reg == '0);
   assign full  = (level_reg == LW'(DEPTH));

   // Only the high-half read retires an entry, which frees a slot for a same-cycle write.
   assign pop       = rd_en_i && !empty && hi_sel_reg;
   assign wr_accept = !clr_i && wr_en_i && (!full || pop);
   assign wr_drop   = !clr_i && wr_en_i && full && !pop;

   fifo_mem #(
      .DEPTH (DEPTH),
      .DW    (DW),
      .AW    (AW)
   ) u_mem (
      .clk_i     (clk_i),
      .wr_en_i   (wr_accept),
      .wr_addr_i (wr_ptr_reg),
      .wr_data_i (wr_data_i),
      .rd_addr_i (rd_ptr_reg),
      .rd_data_o (head_word)
   );

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         level_reg    <= '0;
         hi_sel_reg   <= 1'b0;
         overflow_reg <= 1'b0;
         rd_valid_reg <= 1'b0;
         rd_data_reg  <= '0;
      end else if (clr_i) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         level_reg    <= '0;
         hi_sel_reg   <= 1'b0;
         overflow_reg <= 1'b0;
         rd_valid_reg <= 1'b0;
      end else begin
         rd_valid_reg <= rd_en_i;
         if (rd_en_i) begin
            if (empty) begin
               rd_data_reg <= '0;
            end else if (!hi_sel_reg) begin
               rd_data_reg <= head_word[HW-1:0];
               hi_sel_reg  <= 1'b1;
            end else begin
               rd_data_reg <= head_word[DW-1:HW];
               hi_sel_reg  <= 1'b0;
               rd_ptr_reg  <= rd_ptr_reg + AW'(1);
            end
         end

         if (wr_accept) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end

         if (wr_accept && !pop) begin
            level_reg <= level_reg + LW'(1);
         end else if (pop && !wr_accept) begin
            level_reg <= level_reg - LW'(1);
         end

         if (wr_drop) begin
            overflow_reg <= 1'b1;
         end
      end
   end

   assign rd_data_o  = rd_data_reg;
   assign rd_valid_o = rd_valid_reg;
   assign level_o    = level_reg;
   assign empty_o    = empty;
   assign full_o     = full;
   assign overflow_o = overflow_reg;
   assign irq_o      = (thresh_i != '0) && (level_reg >= thresh_i);

endmodule

// File: tb/tb_meas_fifo.sv
// Self-checking bench for meas_fifo: directed scenarios plus a randomized run,
// all checked against a queue-based model of the result buffer.
module tb_meas_fifo;

   localparam int DEPTH = 16;
   localparam int DW    = 64;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          wr_en;
   logic [DW-1:0] wr_data;
   logic          rd_en;
   logic [31:0]   rd_data;
   logic          rd_valid;
   logic          clr;
   logic [LW-1:0] thresh;
   logic [LW-1:0] level;
   logic          empty;
   logic          full;
   logic          overflow;
   logic          irq;

   int vectors    = 0;
   int miscompares = 0;

   // Reference model: a queue of whole words plus which half is next.
   logic [63:0] mq[$];
   logic        m_hi;
   logic        m_ovf;
   logic        m_valid;
   logic [31:0] m_data;

   meas_fifo #(
      .DEPTH (DEPTH),
      .DW    (DW),
      .LW    (LW)
   ) dut (
      .clk_i      (clk),
      .rst_n_i    (rst_n),
      .wr_en_i    (wr_en),
      .wr_data_i  (wr_data),
      .rd_en_i    (rd_en),
      .rd_data_o  (rd_data),
      .rd_valid_o (rd_valid),
      .clr_i      (clr),
      .thresh_i   (thresh),
      .level_o    (level),
      .empty_o    (empty),
      .full_o     (full),
      .overflow_o (overflow),
      .irq_o      (irq)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      mq.delete();
      m_hi    = 1'b0;
      m_ovf   = 1'b0;
      m_valid = 1'b0;
      m_data  = '0;
   endtask

   // Apply one clock of stimulus and advance the model; outputs settle by the return.
   task automatic cycle(input logic wr, input logic [63:0] d, input logic rd, input logic c);
      logic do_pop;
      wr_en   = wr;
      wr_data = d;
      rd_en   = rd;
      clr     = c;
      do_pop  = 1'b0;
      if (c) begin
         mq.delete();
         m_hi    = 1'b0;
         m_ovf   = 1'b0;
         m_valid = 1'b0;
      end else begin
         m_valid = rd;
         if (rd) begin
            if (mq.size() == 0) begin
               m_data = '0;
            end else if (!m_hi) begin
               m_data = mq[0][31:0];
               m_hi   = 1'b1;
            end else begin
               m_data = mq[0][63:32];
               m_hi   = 1'b0;
               do_pop = 1'b1;
            end
         end
         if (do_pop) void'(mq.pop_front());
         if (wr) begin
            if (mq.size() < DEPTH) mq.push_back(d);
            else m_ovf = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      rd_en = 1'b0;
      clr   = 1'b0;
   endtask

   task automatic test_reset();
      rst_n   = 1'b0;
      wr_en   = 1'b0;
      wr_data = '0;
      rd_en   = 1'b0;
      clr     = 1'b0;
      thresh  = '0;
      model_reset();
      #12;
      vectors++; if (level !== 5'd0) begin miscompares++; $display("FAIL reset_level got %0d want 0", level); end
      vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty got %b want 1", empty); end
      vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL reset_full got %b want 0", full); end
      vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_ovf got %b want 0", overflow); end
      vectors++; if (rd_valid !== 1'b0 || rd_data !== 32'h0) begin miscompares++; $display("FAIL reset_rd got %b/%h want 0/0", rd_valid, rd_data); end
      vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq got %b want 0", irq); end
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      $display("reset: level=%0d empty=%b", level, empty);
   endtask

   task automatic test_basic();
      cycle(1'b1, 64'h0000_0100_0000_0064, 1'b0, 1'b0);
      vectors++; if (level !== 5'd1) begin miscompares++; $display("FAIL basic_level1 got %0d want 1", level); end
      cycle(1'b0, '0, 1'b1, 1'b0);
      $display("basic rd0: valid=%b data=%h level=%0d", rd_valid, rd_data, level);
      vectors++; if (rd_valid !== 1'b1 || rd_data !== 32'h0000_0064) begin miscompares++; $display("FAIL basic_low got %b/%h want 1/00000064", rd_valid, rd_data); end
      vectors++; if (level !== 5'd1) begin miscompares++; $display("FAIL basic_level2 got %0d want 1", level); end
      cycle(1'b0, '0, 1'b1, 1'b0);
      $display("basic rd1: valid=%b data=%h level=%0d", rd_valid, rd_data, level);
      vectors++; if (rd_data !== 32'h0000_0100) begin miscompares++; $display("FAIL basic_high got %h want 00000100", rd_data); end
      vectors++; if (level !== 5'd0 || empty !== 1'b1) begin miscompares++; $display("FAIL basic_drain got %0d/%b want 0/1", level, empty); end
   endtask

   task automatic test_full();
      logic [31:0] exp;
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, {32'h1000 + 32'(i), 32'(i)}, 1'b0, 1'b0);
      vectors++; if (overflow !== 1'b0 || full !== 1'b1) begin miscompares++; $display("FAIL full_pre got ovf=%b full=%b want 0/1", overflow, full); end
      cycle(1'b1, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0, 1'b0);
      $display("full: level=%0d full=%b ovf=%b", level, full, overflow);
      vectors++; if (level !== 5'd16 || full !== 1'b1) begin miscompares++; $display("FAIL full_level got %0d/%b want 16/1", level, full); end
      vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL full_ovf got %b want 1", overflow); end
      for (int k = 0; k < 2 * DEPTH; k++) begin
         cycle(1'b0, '0, 1'b1, 1'b0);
         exp = (k % 2 == 1) ? 32'h1000 + 32'(k / 2) : 32'(k / 2);
         $display("full drain %0d: data=%h", k, rd_data);
         vectors++; if (rd_valid !== 1'b1 || rd_data !== exp) begin miscompares++; $display("FAIL full_drain%0d got %h want %h", k, rd_data, exp); end
      end
      vectors++; if (empty !== 1'b1 || overflow !== 1'b1) begin miscompares++; $display("FAIL full_end got empty=%b ovf=%b want 1/1", empty, overflow); end
      cycle(1'b0, '0, 1'b0, 1'b1);
      vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL full_clr_ovf got %b want 0", overflow); end
   endtask

   task automatic test_full_simul();
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, {32'h2000 + 32'(i), 32'h100 + 32'(i)}, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0);
      vectors++; if (rd_data !== 32'h100) begin miscompares++; $display("FAIL simul_low got %h want 00000100", rd_data); end
      cycle(1'b1, 64'hABCD_0001_ABCD_0002, 1'b1, 1'b0);
      $display("simul: data=%h level=%0d ovf=%b", rd_data, level, overflow);
      vectors++; if (rd_data !== 32'h2000) begin miscompares++; $display("FAIL simul_high got %h want 00002000", rd_data); end
      vectors++; if (level !== 5'd16 || overflow !== 1'b0) begin miscompares++; $display("FAIL simul_level got %0d/%b want 16/0", level, overflow); end
      for (int k = 0; k < 2 * (DEPTH - 1); k++) begin
         cycle(1'b0, '0, 1'b1, 1'b0);
         vectors++; if (rd_data !== m_data) begin miscompares++; $display("FAIL simul_drain%0d got %h want %h", k, rd_data, m_data); end
      end
      cycle(1'b0, '0, 1'b1, 1'b0);
      vectors++; if (rd_data !== 32'hABCD_0002) begin miscompares++; $display("FAIL simul_last_lo got %h want abcd0002", rd_data); end
      cycle(1'b0, '0, 1'b1, 1'b0);
      $display("simul last: data=%h empty=%b", rd_data, empty);
      vectors++; if (rd_data !== 32'hABCD_0001 || empty !== 1'b1) begin miscompares++; $display("FAIL simul_last_hi got %h/%b want abcd0001/1", rd_data, empty); end
   endtask

   task automatic test_empty_read();
      cycle(1'b0, '0, 1'b1, 1'b0);
      $display("empty read: valid=%b data=%h", rd_valid, rd_data);
      vectors++; if (rd_valid !== 1'b1 || rd_data !== 32'h0) begin miscompares++; $display("FAIL empty_rd got %b/%h want 1/0", rd_valid, rd_data); end
      vectors++; if (level !== 5'd0) begin miscompares++; $display("FAIL empty_level got %0d want 0", level); end
      cycle(1'b0, '0, 1'b0, 1'b0);
      vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL empty_valid_pulse got %b want 0", rd_valid); end
      cycle(1'b1, 64'h0000_0007_0000_0005, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0);
      vectors++; if (rd_data !== 32'h5) begin miscompares++; $display("FAIL empty_then_lo got %h want 00000005", rd_data); end
      cycle(1'b0, '0, 1'b1, 1'b0);
      vectors++; if (rd_data !== 32'h7) begin miscompares++; $display("FAIL empty_then_hi got %h want 00000007", rd_data); end
   endtask

   task automatic test_irq();
      thresh = 5'd4;
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 64'(i), 1'b0, 1'b0);
         vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_below%0d got %b want 0", i, irq); end
      end
      cycle(1'b1, 64'h3, 1'b0, 1'b0);
      $display("irq: level=%0d irq=%b", level, irq);
      vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL irq_at got %b want 1", irq); end
      cycle(1'b0, '0, 1'b1, 1'b0);
      vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL irq_lowread got %b want 1", irq); end
      cycle(1'b0, '0, 1'b1, 1'b0);
      vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_pop got %b want 0", irq); end
      thresh = 5'd0;
      cycle(1'b0, '0, 1'b0, 1'b1);
      for (int i = 0; i < DEPTH; i++) begin
         cycle(1'b1, 64'(i), 1'b0, 1'b0);
         vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_disabled%0d got %b want 0", i, irq); end
      end
      cycle(1'b0, '0, 1'b0, 1'b1);
   endtask

   task automatic test_clear();
      for (int i = 0; i < DEPTH + 1; i++) cycle(1'b1, {32'h3000 + 32'(i), 32'h300 + 32'(i)}, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0);
      vectors++; if (rd_data !== 32'h300 || overflow !== 1'b1) begin miscompares++; $display("FAIL clr_pre got %h/%b want 00000300/1", rd_data, overflow); end
      cycle(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
      $display("clear: level=%0d ovf=%b valid=%b", level, overflow, rd_valid);
      vectors++; if (level !== 5'd0 || empty !== 1'b1) begin miscompares++; $display("FAIL clr_level got %0d/%b want 0/1", level, empty); end
      vectors++; if (overflow !== 1'b0 || rd_valid !== 1'b0) begin miscompares++; $display("FAIL clr_flags got ovf=%b valid=%b want 0/0", overflow, rd_valid); end
      cycle(1'b1, 64'h0000_00BB_0000_00AA, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0);
      vectors++; if (rd_data !== 32'hAA) begin miscompares++; $display("FAIL clr_post_lo got %h want 000000aa", rd_data); end
      cycle(1'b0, '0, 1'b1, 1'b0);
      vectors++; if (rd_data !== 32'hBB || empty !== 1'b1) begin miscompares++; $display("FAIL clr_post_hi got %h/%b want 000000bb/1", rd_data, empty); end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < DEPTH + 1; i++) cycle(1'b1, {32'h4000 + 32'(i), 32'(i)}, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      $display("async reset: level=%0d ovf=%b valid=%b", level, overflow, rd_valid);
      vectors++; if (level !== 5'd0 || empty !== 1'b1 || full !== 1'b0) begin miscompares++; $display("FAIL arst_level got %0d/%b/%b want 0/1/0", level, empty, full); end
      vectors++; if (overflow !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 32'h0) begin miscompares++; $display("FAIL arst_flags got %b/%b/%h want 0/0/0", overflow, rd_valid, rd_data); end
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      cycle(1'b1, 64'h0000_0022_0000_0011, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0);
      vectors++; if (rd_data !== 32'h11) begin miscompares++; $display("FAIL arst_post_lo got %h want 00000011", rd_data); end
      cycle(1'b0, '0, 1'b1, 1'b0);
      vectors++; if (rd_data !== 32'h22) begin miscompares++; $display("FAIL arst_post_hi got %h want 00000022", rd_data); end
   endtask

   task automatic test_random();
      logic        w, r, c;
      logic [63:0] d;
      int          exp_level;
      logic        exp_irq;
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 99) < 5) thresh = LW'($urandom_range(0, DEPTH));
         w = ($urandom_range(0, 99) < 55);
         r = ($urandom_range(0, 99) < 50);
         c = ($urandom_range(0, 199) == 0);
         d = {$urandom(), $urandom()};
         cycle(w, d, r, c);
         exp_level = mq.size();
         exp_irq   = (thresh != 0) && (exp_level >= int'(thresh));
         $display("rand %0d: wr=%b rd=%b clr=%b level=%0d valid=%b data=%h", n, w, r, c, level, rd_valid, rd_data);
         vectors++; if (level !== LW'(exp_level)) begin miscompares++; $display("FAIL rand_level%0d got %0d want %0d", n, level, exp_level); end
         vectors++; if (empty !== (exp_level == 0) || full !== (exp_level == DEPTH)) begin miscompares++; $display("FAIL rand_flags%0d got e=%b f=%b want level %0d", n, empty, full, exp_level); end
         vectors++; if (overflow !== m_ovf) begin miscompares++; $display("FAIL rand_ovf%0d got %b want %b", n, overflow, m_ovf); end
         vectors++; if (irq !== exp_irq) begin miscompares++; $display("FAIL rand_irq%0d got %b want %b", n, irq, exp_irq); end
         vectors++; if (rd_valid !== m_valid) begin miscompares++; $display("FAIL rand_valid%0d got %b want %b", n, rd_valid, m_valid); end
         if (m_valid) begin
            vectors++; if (rd_data !== m_data) begin miscompares++; $display("FAIL rand_data%0d got %h want %h", n, rd_data, m_data); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_full();
      test_full_simul();
      test_empty_read();
      test_irq();
      test_clear();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
